plot_sequencer: RTL and testbench
=================================

Name: plot_sequencer

Overview:
Round-robin pixel-plot sequencer for the 160x120 VGA frame buffer. It serialises N player head positions plus one round-timer bar pixel into a single valid/ready plot stream for the vga_adapter write port. It also owns the round timer: it starts a round, advances the bar on timer ticks and ends the round. It is the parametrised successor of the fixed 4-player draw FSM/datapath pair, adding dead-player skipping, off-screen suppression, a back-pressure handshake and explicit round start/end.

Parameters:
N_PLAYERS, 4, number of player slots (1..8)
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
COLOUR_W, 3, colour width
X_MAX, 160, first illegal x value
Y_MAX, 120, first illegal y value
PLAYER_COLOURS, {3'b110,3'b100,3'b010,3'b001}, packed N_PLAYERS*COLOUR_W colour table; player 0 occupies the LSBs
TIMER_COLOUR, 3'b111, colour of the timer bar
TIMER_ROW, 119, y coordinate of the timer bar
TIMER_STEPS, 159, number of ticks in a round

Ports:
CLOCK_50  in  1  system clock, 50 MHz
resetn  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse that begins a round
timer_tick  in  1  one-cycle round-timer pulse
positions  in  N_PLAYERS*(X_W+Y_W)  player i at [i*(X_W+Y_W) +: X_W+Y_W], with x in the upper X_W bits
alive  in  N_PLAYERS  per-player draw enable
plot_ready  in  1  sink accepts the current pixel
x  out  X_W  plot x
y  out  Y_W  plot y
colour  out  COLOUR_W  plot colour
plot_valid  out  1  x/y/colour hold a pixel to write
slot  out  clog2(N_PLAYERS+1)  slot owning the current output; value N_PLAYERS = timer
running  out  1  round in progress
round_done  out  1  one-cycle pulse at end of round
timer_x  out  X_W  current timer bar column

Behaviour:
- Clocking/reset: one clock, CLOCK_50. Reset is synchronous and active-low on resetn.
- Reset state: all outputs 0; FSM in IDLE; slot pointer at 0.
- Reset taken mid-round or mid-handshake: abandon the pixel; plot_valid is 0 on the next cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start:
  - next cycle: RUN, running=1, timer_x=0, slot pointer=0.
  - start is ignored while in RUN.
- Output register loads the next slot only on an advance cycle: any cycle in RUN where !plot_valid || plot_ready.
- While plot_valid=1 and plot_ready=0: x, y, colour and slot are held stable.
- Slot load rules:
  - player slot i:
    - plot_valid=1, x/y taken from positions, colour=PLAYER_COLOURS[i].
    - Exception: alive[i]=0, x>=X_MAX or y>=Y_MAX produces a bubble: plot_valid=0 for that cycle; slot still reports i.
  - timer slot: x=timer_x, y=TIMER_ROW, colour=TIMER_COLOUR, plot_valid=1.
- Slot order: pointer wraps N_PLAYERS -> 0.
- Latency: positions are sampled in the cycle the slot loads; the pixel is visible 1 cycle later. With plot_ready tied high, one full sweep takes N_PLAYERS+1 cycles.
- Timer: counts ticks only while running.
  - timer_tick with timer_x < TIMER_STEPS-1: timer_x+1.
  - timer_tick with timer_x == TIMER_STEPS-1: next cycle running=0, state DONE, round_done=1 for one cycle, plot_valid=0 (in-flight pixel dropped).
  - timer_x holds its final value in DONE.
- Simultaneous timer_tick and slot advance: both take effect; the timer slot plots the pre-increment timer_x if it loads in that cycle.
- Simultaneous start and final tick cannot occur (start is ignored in RUN).
- Arithmetic: timer_x is X_W wide and never wraps, because TIMER_STEPS <= 2^X_W is checked at elaboration.

Decomposition:
- Shared package plot_pkg: FSM state enum {IDLE,RUN,DONE}, X_W/Y_W/COLOUR_W defaults, default colour constants, X_MAX/Y_MAX.
- One sub-module, round_timer: owns timer_x, running and round_done; inputs start and timer_tick.
- plot_sequencer keeps the slot pointer and output register.

Test Plan:
- Round start, free-running sink: reset, start, plot_ready=1, all alive, positions p0=(10,20) p1=(30,40) p2=(50,60) p3=(70,80) -> valid pixels in order: (10,20,001), (30,40,010), (50,60,100), (70,80,110), (0,119,111); then the sequence repeats.
- Back-pressure: plot_ready=0 for 5 cycles while slot 1 is valid -> x=30, y=40, colour=010 stable for all 5 cycles; the next cycle after plot_ready=1 loads slot 2.
- Skip/suppress: alive=4'b1101 and p3=(160,5) -> slots 1 and 3 are bubbles (plot_valid=0); only p0, p2 and the timer pixel are emitted.
- Round end: TIMER_STEPS=4, send 4 ticks -> timer_x goes 0,1,2,3; then running=0 and round_done is a single-cycle pulse; no further plot_valid until the next start, which restarts at timer_x=0.
- Reset mid-round: resetn=0 for 1 cycle while plot_valid=1 and plot_ready=0 -> next cycle all outputs 0 and state IDLE; start behaves normally afterwards.
- Tick and timer-slot collision: timer_tick in the cycle the timer slot loads with timer_x=2 -> emitted x=2, timer_x becomes 3.

Source files
------------

// File: rtl/plot_pkg.sv
// Shared types and default constants for the plot sequencer and its round timer.
package plot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } plot_state_e;

    localparam int DEF_X_W       = 8;
    localparam int DEF_Y_W       = 7;
    localparam int DEF_COLOUR_W  = 3;
    localparam int DEF_X_MAX     = 160;
    localparam int DEF_Y_MAX     = 120;
    localparam int DEF_TIMER_ROW = 119;
    localparam int DEF_TIMER_STEPS = 159;

    localparam logic [11:0] DEF_PLAYER_COLOURS = {3'b110, 3'b100, 3'b010, 3'b001};
    localparam logic [2:0]  DEF_TIMER_COLOUR   = 3'b111;

    // Width of a slot index able to name every player plus the timer slot.
    function automatic int slot_width(input int n_players);
        return $clog2(n_players + 1);
    endfunction

endpackage

// File: rtl/plot_sequencer_if.sv
// Pixel plot stream between the sequencer (master) and the frame-buffer write port (slave).
interface plot_sequencer_if
    import plot_pkg::*;
#(
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COLOUR_W = DEF_COLOUR_W,
    parameter int SLOT_W   = 3
);
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot_valid;
    logic                plot_ready;
    logic [SLOT_W-1:0]   slot;

    modport master (output x, y, colour, plot_valid, slot, input plot_ready);
    modport slave  (input x, y, colour, plot_valid, slot, output plot_ready);
endinterface

// File: rtl/plot_sequencer_round_timer.sv
// Round timer: IDLE/RUN/DONE FSM, timer bar column and the end-of-round pulse.
module round_timer
    import plot_pkg::*;
#(
    parameter int X_W         = DEF_X_W,
    parameter int TIMER_STEPS = DEF_TIMER_STEPS
) (
    input  logic           CLOCK_50,
    input  logic           resetn,
    input  logic           start,
    input  logic           timer_tick,
    output logic           running,
    output logic           round_done,
    output logic           last_tick,
    output logic [X_W-1:0] timer_x
);

    localparam logic [X_W-1:0] TIMER_LAST = X_W'(TIMER_STEPS - 1);

    if (TIMER_STEPS < 1 || TIMER_STEPS > (1 << X_W)) begin : g_bad_steps
        $error("round_timer: TIMER_STEPS must lie in 1..2**X_W");
    end

    plot_state_e    state_r, state_nxt_s;
    logic [X_W-1:0] timer_x_r, timer_x_nxt_s;
    logic           round_done_r, round_done_nxt_s;
    logic           at_last_s;

    // State register: FSM state, bar column and end-of-round pulse.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_r      <= IDLE;
            timer_x_r    <= '0;
            round_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            timer_x_r    <= timer_x_nxt_s;
            round_done_r <= round_done_nxt_s;
        end
    end

    // Next state: start launches a round, the tick at the last column closes it.
    always_comb begin
        state_nxt_s      = state_r;
        timer_x_nxt_s    = timer_x_r;
        round_done_nxt_s = 1'b0;
        at_last_s        = (timer_x_r == TIMER_LAST);
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt_s   = RUN;
                    timer_x_nxt_s = '0;
                end else begin
                    state_nxt_s   = state_r;
                end
            end
            RUN: begin
                if (timer_tick && at_last_s) begin
                    state_nxt_s      = DONE;
                    round_done_nxt_s = 1'b1;
                end else if (timer_tick) begin
                    timer_x_nxt_s = timer_x_r + X_W'(1);
                end else begin
                    timer_x_nxt_s = timer_x_r;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                timer_x_nxt_s = '0;
            end
        endcase
    end

    // Outputs decoded from registered state; last_tick lets the sequencer drop its pixel.
    always_comb begin
        running    = (state_r == RUN);
        round_done = round_done_r;
        timer_x    = timer_x_r;
        last_tick  = (state_r == RUN) && timer_tick && (timer_x_r == TIMER_LAST);
    end

endmodule

// File: rtl/plot_sequencer.sv
// Round-robin plot sequencer: serialises player heads plus the timer bar pixel into one stream.
module plot_sequencer
    import plot_pkg::*;
#(
    parameter int N_PLAYERS = 4,
    parameter int X_W       = DEF_X_W,
    parameter int Y_W       = DEF_Y_W,
    parameter int COLOUR_W  = DEF_COLOUR_W,
    parameter int X_MAX     = DEF_X_MAX,
    parameter int Y_MAX     = DEF_Y_MAX,
    parameter logic [N_PLAYERS*COLOUR_W-1:0] PLAYER_COLOURS = DEF_PLAYER_COLOURS,
    parameter logic [COLOUR_W-1:0]           TIMER_COLOUR   = DEF_TIMER_COLOUR,
    parameter int TIMER_ROW   = DEF_TIMER_ROW,
    parameter int TIMER_STEPS = DEF_TIMER_STEPS
) (
    input  logic                           CLOCK_50,
    input  logic                           resetn,
    input  logic                           start,
    input  logic                           timer_tick,
    input  logic [N_PLAYERS*(X_W+Y_W)-1:0] positions,
    input  logic [N_PLAYERS-1:0]           alive,
    plot_sequencer_if.master               plot,
    output logic                           running,
    output logic                           round_done,
    output logic [X_W-1:0]                 timer_x
);

    localparam int SLOT_W = slot_width(N_PLAYERS);
    localparam int XY_W   = X_W + Y_W;

    if (N_PLAYERS < 1 || N_PLAYERS > 8) begin : g_bad_players
        $error("plot_sequencer: N_PLAYERS must lie in 1..8");
    end

    logic                last_tick_s;
    logic                launch_s, advance_s, is_timer_s, on_screen_s, hit_s;
    logic [SLOT_W-1:0]   ptr_r, ptr_nxt_s, slot_r;
    logic [XY_W-1:0]     sel_pos_s;
    logic [COLOUR_W-1:0] sel_colour_s, load_colour_s, colour_r;
    logic                sel_alive_s, load_valid_s, plot_valid_r;
    logic [X_W-1:0]      pos_x_s, load_x_s, x_r;
    logic [Y_W-1:0]      pos_y_s, load_y_s, y_r;

    round_timer #(
        .X_W         (X_W),
        .TIMER_STEPS (TIMER_STEPS)
    ) u_round_timer (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .start      (start),
        .timer_tick (timer_tick),
        .running    (running),
        .round_done (round_done),
        .last_tick  (last_tick_s),
        .timer_x    (timer_x)
    );

    // Player mux: one-hot OR of the slot the pointer names (all zero on the timer slot).
    always_comb begin
        sel_pos_s    = '0;
        sel_colour_s = '0;
        sel_alive_s  = 1'b0;
        hit_s        = 1'b0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            hit_s        = (ptr_r == SLOT_W'(i));
            sel_pos_s    = sel_pos_s | (positions[i*XY_W +: XY_W] & {XY_W{hit_s}});
            sel_colour_s = sel_colour_s | (PLAYER_COLOURS[i*COLOUR_W +: COLOUR_W] & {COLOUR_W{hit_s}});
            sel_alive_s  = sel_alive_s | (alive[i] & hit_s);
        end
    end

    // Pixel to load on an advance; dead or off-screen players become bubbles.
    always_comb begin
        pos_x_s       = sel_pos_s[XY_W-1 -: X_W];
        pos_y_s       = sel_pos_s[Y_W-1:0];
        is_timer_s    = (ptr_r == SLOT_W'(N_PLAYERS));
        on_screen_s   = sel_alive_s
                        && ({1'b0, pos_x_s} < (X_W+1)'(X_MAX))
                        && ({1'b0, pos_y_s} < (Y_W+1)'(Y_MAX));
        load_x_s      = is_timer_s ? timer_x : pos_x_s;
        load_y_s      = is_timer_s ? Y_W'(TIMER_ROW) : pos_y_s;
        load_colour_s = is_timer_s ? TIMER_COLOUR : sel_colour_s;
        load_valid_s  = is_timer_s || on_screen_s;
        ptr_nxt_s     = is_timer_s ? '0 : ptr_r + SLOT_W'(1);
        launch_s      = start && !running;
        advance_s     = running && (!plot_valid_r || plot.plot_ready);
    end

    // Output register: round end drops the pixel, launch rewinds, advance loads the next slot.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            ptr_r        <= '0;
            slot_r       <= '0;
            x_r          <= '0;
            y_r          <= '0;
            colour_r     <= '0;
            plot_valid_r <= 1'b0;
        end else if (last_tick_s) begin
            plot_valid_r <= 1'b0;
        end else if (launch_s) begin
            ptr_r        <= '0;
            plot_valid_r <= 1'b0;
        end else if (advance_s) begin
            ptr_r        <= ptr_nxt_s;
            slot_r       <= ptr_r;
            x_r          <= load_x_s;
            y_r          <= load_y_s;
            colour_r     <= load_colour_s;
            plot_valid_r <= load_valid_s;
        end
    end

    assign plot.x          = x_r;
    assign plot.y          = y_r;
    assign plot.colour     = colour_r;
    assign plot.plot_valid = plot_valid_r;
    assign plot.slot       = slot_r;

endmodule

// File: tb/tb_plot_sequencer.sv
// Directed bench for plot_sequencer: 4 players, 4-step round timer, hand-computed pixel tables.
module tb_plot_sequencer;

    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int SW = 3;

    logic                  CLOCK_50;
    logic                  resetn;
    logic                  start;
    logic                  timer_tick;
    logic [N*(XW+YW)-1:0]  positions;
    logic [N-1:0]          alive;
    logic                  running;
    logic                  round_done;
    logic [XW-1:0]         timer_x;

    int n_checks;
    int n_failures;

    plot_sequencer_if #(.X_W(XW), .Y_W(YW), .COLOUR_W(CW), .SLOT_W(SW)) plot ();

    plot_sequencer #(
        .N_PLAYERS   (N),
        .TIMER_STEPS (4)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .start      (start),
        .timer_tick (timer_tick),
        .positions  (positions),
        .alive      (alive),
        .plot       (plot),
        .running    (running),
        .round_done (round_done),
        .timer_x    (timer_x)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_pos(input int i, input int px, input int py);
        positions[i*(XW+YW) +: (XW+YW)] = {8'(px), 7'(py)};
    endtask

    task automatic check_pixel(input string tag, input int v, input int ex, input int ey,
                               input int ec, input int es);
        check_value({tag, ".valid"}, 32'(plot.plot_valid), v);
        check_value({tag, ".slot"}, 32'(plot.slot), es);
        if (v != 0) begin
            check_value({tag, ".x"}, 32'(plot.x), ex);
            check_value({tag, ".y"}, 32'(plot.y), ey);
            check_value({tag, ".colour"}, 32'(plot.colour), ec);
        end
    endtask

    task automatic check_idle(input string tag);
        check_value({tag, ".x"}, 32'(plot.x), 0);
        check_value({tag, ".y"}, 32'(plot.y), 0);
        check_value({tag, ".colour"}, 32'(plot.colour), 0);
        check_value({tag, ".valid"}, 32'(plot.plot_valid), 0);
        check_value({tag, ".slot"}, 32'(plot.slot), 0);
        check_value({tag, ".running"}, 32'(running), 0);
        check_value({tag, ".round_done"}, 32'(round_done), 0);
        check_value({tag, ".timer_x"}, 32'(timer_x), 0);
    endtask

    // Expected sweep with all players alive and the timer at column 0.
    int sx[5] = '{10, 30, 50, 70, 0};
    int sy[5] = '{20, 40, 60, 80, 119};
    int sc[5] = '{1, 2, 4, 6, 7};

    // Skip/suppress then boundary table: valid, x, y, colour, slot.
    int kv[12] = '{0, 1, 1, 0, 1, 0, 1, 1, 1, 0, 1, 1};
    int kx[12] = '{0, 0, 10, 0, 50, 0, 0, 159, 30, 0, 70, 0};
    int ky[12] = '{0, 119, 20, 0, 60, 0, 119, 119, 40, 0, 80, 119};
    int kc[12] = '{0, 7, 1, 0, 4, 0, 7, 1, 2, 0, 6, 7};
    int ks[12] = '{3, 4, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4};

    initial begin
        n_checks        = 0;
        n_failures      = 0;
        resetn          = 1'b0;
        start           = 1'b0;
        timer_tick      = 1'b0;
        positions       = '0;
        alive           = '0;
        plot.plot_ready = 1'b1;

        cycle();
        cycle();
        check_idle("reset");
        resetn = 1'b1;
        cycle();
        check_value("idle.valid", 32'(plot.plot_valid), 0);
        check_value("idle.running", 32'(running), 0);

        // Round start with a free-running sink: two full sweeps.
        set_pos(0, 10, 20);
        set_pos(1, 30, 40);
        set_pos(2, 50, 60);
        set_pos(3, 70, 80);
        alive = 4'b1111;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check_value("start.running", 32'(running), 1);
        check_value("start.timer_x", 32'(timer_x), 0);
        check_value("start.valid", 32'(plot.plot_valid), 0);
        for (int k = 0; k < 10; k++) begin
            cycle();
            check_pixel($sformatf("sweep%0d", k), 1, sx[k%5], sy[k%5], sc[k%5], k % 5);
        end

        // Back-pressure while slot 1 is presented.
        cycle();
        check_pixel("bp.slot0", 1, 10, 20, 1, 0);
        cycle();
        check_pixel("bp.slot1", 1, 30, 40, 2, 1);
        plot.plot_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check_pixel($sformatf("bp.hold%0d", k), 1, 30, 40, 2, 1);
        end
        plot.plot_ready = 1'b1;
        cycle();
        check_pixel("bp.release", 1, 50, 60, 4, 2);

        // Dead / off-screen bubbles, then screen-edge boundaries.
        alive = 4'b1101;
        set_pos(3, 160, 5);
        for (int k = 0; k < 12; k++) begin
            if (k == 7) begin
                alive = 4'b1111;
                set_pos(0, 159, 119);
                set_pos(2, 50, 120);
                set_pos(3, 70, 80);
            end
            cycle();
            check_pixel($sformatf("skip%0d", k), kv[k], kx[k], ky[k], kc[k], ks[k]);
        end

        // Ticks during the sweep, a start ignored in RUN, and a tick as the timer slot loads.
        set_pos(0, 10, 20);
        set_pos(2, 50, 60);
        timer_tick = 1'b1;
        cycle();
        check_pixel("tick.slot0", 1, 10, 20, 1, 0);
        check_value("tick.timer_x1", 32'(timer_x), 1);
        cycle();
        check_pixel("tick.slot1", 1, 30, 40, 2, 1);
        check_value("tick.timer_x2", 32'(timer_x), 2);
        timer_tick = 1'b0;
        start      = 1'b1;
        cycle();
        start = 1'b0;
        check_pixel("ignstart.slot2", 1, 50, 60, 4, 2);
        check_value("ignstart.timer_x", 32'(timer_x), 2);
        check_value("ignstart.running", 32'(running), 1);
        cycle();
        check_pixel("tick.slot3", 1, 70, 80, 6, 3);
        timer_tick = 1'b1;
        cycle();
        timer_tick = 1'b0;
        check_pixel("collide", 1, 2, 119, 7, 4);
        check_value("collide.timer_x", 32'(timer_x), 3);

        // Final tick with a pixel in flight ends the round.
        timer_tick = 1'b1;
        cycle();
        timer_tick = 1'b0;
        check_value("end.running", 32'(running), 0);
        check_value("end.round_done", 32'(round_done), 1);
        check_value("end.valid", 32'(plot.plot_valid), 0);
        check_value("end.timer_x", 32'(timer_x), 3);
        cycle();
        check_value("done.round_done", 32'(round_done), 0);
        check_value("done.valid", 32'(plot.plot_valid), 0);
        timer_tick = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_value($sformatf("done%0d.valid", k), 32'(plot.plot_valid), 0);
            check_value($sformatf("done%0d.timer_x", k), 32'(timer_x), 3);
            check_value($sformatf("done%0d.round_done", k), 32'(round_done), 0);
        end
        timer_tick = 1'b0;
        start      = 1'b1;
        cycle();
        start = 1'b0;
        check_value("restart.running", 32'(running), 1);
        check_value("restart.timer_x", 32'(timer_x), 0);
        check_value("restart.valid", 32'(plot.plot_valid), 0);
        cycle();
        check_pixel("restart.slot0", 1, 10, 20, 1, 0);

        // Reset mid-handshake, then a normal start.
        plot.plot_ready = 1'b0;
        cycle();
        check_pixel("stall.slot0", 1, 10, 20, 1, 0);
        resetn = 1'b0;
        cycle();
        resetn          = 1'b1;
        plot.plot_ready = 1'b1;
        check_idle("midreset");
        cycle();
        check_value("postreset.running", 32'(running), 0);
        check_value("postreset.valid", 32'(plot.plot_valid), 0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check_value("postreset.start", 32'(running), 1);
        cycle();
        check_pixel("postreset.slot0", 1, 10, 20, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_failures);
        $finish;
    end

endmodule
